// File: rtl/dmem_loader_pkg.sv
// dmem_loader_pkg
//   Shared types and constants for the data-memory image loader.
//   state_t           : loader FSM encoding
//   WORD_BYTES        : bytes per assembled memory word
//   ADDR_STEP         : byte-address increment between consecutive words
//   DEFAULT_MAX_WORDS : default upper bound on a legal word_count
package dmem_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   localparam int WORD_BYTES        = 4;
   localparam int ADDR_STEP         = 4;
   localparam int DEFAULT_MAX_WORDS = 1024;

endpackage

// File: rtl/dmem_loader_byte_packer.sv
// dmem_loader_byte_packer
//   Assembles a little-endian 32-bit word from a byte stream. The first byte
//   pushed after a clear lands in bits [7:0].
// Ports:
//   i_clk        : system clock
//   i_reset      : synchronous active-high reset
//   i_clear      : drop any partial word and restart at lane 0
//   i_push       : accept i_byte into the current lane this cycle
//   i_byte       : byte to insert
//   o_word_next  : current word with i_byte merged into the current lane
//   o_word_full  : this push fills the last lane (o_word_next is complete)
module dmem_loader_byte_packer
   import dmem_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clear,
   input  logic        i_push,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word_next,
   output logic        o_word_full
);

   localparam int LANE_W = $clog2(WORD_BYTES);

   logic [LANE_W-1:0] r_lane;
   logic [31:0]       r_word;

   // The merged word is exposed combinationally so the top can capture the
   // complete word on the same edge that accepts the last byte.
   always_comb begin
      o_word_next                = r_word;
      o_word_next[8*r_lane +: 8] = i_byte;
   end

   assign o_word_full = i_push & (r_lane == LANE_W'(WORD_BYTES - 1));

   // Lane counter wraps to 0 after the last lane, ready for the next word.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_lane <= '0;
         r_word <= '0;
      end else if (i_push) begin
         r_word <= o_word_next;
         r_lane <= r_lane + LANE_W'(1);
      end
   end

endmodule

// File: rtl/dmem_loader.sv
// dmem_loader
//   Loads a byte stream into data memory through the CPU's external write
//   port, holding the CPU in reset until the image is complete.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | after reset; CPU held, waiting for start
//   LOAD  | collecting bytes of the current word (byte_ready high)
//   WRITE | one-cycle memory write of the assembled word
//   RUN   | image loaded, CPU released; a new start reloads
//
// Ports:
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_start            : load request (honoured in IDLE and RUN only)
//   i_word_count       : words to load, latched on an accepted start
//   i_byte_valid       : stream byte valid
//   i_byte_data        : stream byte
//   o_byte_ready       : loader takes a byte this cycle
//   o_Ext_MemWrite     : data-memory write strobe
//   o_Ext_WriteData    : word being written (registered)
//   o_Ext_DataAdr      : byte address being written (registered)
//   o_cpu_reset        : holds the CPU and selects the external port
//   o_busy             : high in LOAD and WRITE
//   o_done             : pulse with the last word's write
//   o_error            : sticky illegal word_count flag
module dmem_loader
   import dmem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = DEFAULT_MAX_WORDS,
   parameter int          CW        = 16
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_start,
   input  logic [CW-1:0] i_word_count,
   input  logic          i_byte_valid,
   input  logic [7:0]    i_byte_data,
   output logic          o_byte_ready,
   output logic          o_Ext_MemWrite,
   output logic [31:0]   o_Ext_WriteData,
   output logic [31:0]   o_Ext_DataAdr,
   output logic          o_cpu_reset,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_error
);

   localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);

   state_t        r_state;
   state_t        w_state_next;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_index;
   logic [31:0]   r_wdata;
   logic [31:0]   r_adr;
   logic          r_error;

   logic          w_push;
   logic          w_word_full;
   logic [31:0]   w_word_next;
   logic          w_start_seen;
   logic          w_illegal;
   logic          w_zero;
   logic          w_load_go;
   logic          w_last;

   assign w_start_seen = i_start & ((r_state == ST_IDLE) | (r_state == ST_RUN));
   assign w_illegal    = 32'(i_word_count) > MAX_W32;
   assign w_zero       = (i_word_count == '0);
   assign w_load_go    = w_start_seen & ~w_illegal & ~w_zero;
   assign w_last       = ((r_index + CW'(1)) == r_count);
   assign w_push       = i_byte_valid & o_byte_ready;

   dmem_loader_byte_packer u_packer (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_clear     (w_load_go),
      .i_push      (w_push),
      .i_byte      (i_byte_data),
      .o_word_next (w_word_next),
      .o_word_full (w_word_full)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      o_byte_ready   = 1'b0;
      o_Ext_MemWrite = 1'b0;
      o_cpu_reset    = 1'b1;
      o_busy         = 1'b0;
      o_done         = 1'b0;
      case (r_state)
         ST_IDLE, ST_RUN: begin
            o_cpu_reset = (r_state == ST_IDLE);
            if (w_start_seen && !w_illegal) begin
               w_state_next = w_zero ? ST_RUN : ST_LOAD;
            end
         end
         ST_LOAD: begin
            o_byte_ready = 1'b1;
            o_busy       = 1'b1;
            if (w_word_full) begin
               w_state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            o_Ext_MemWrite = 1'b1;
            o_busy         = 1'b1;
            if (w_last) begin
               o_done       = 1'b1;
               w_state_next = ST_RUN;
            end else begin
               w_state_next = ST_LOAD;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Data and address are captured on the edge that enters WRITE, so they
   // are stable for the whole write cycle and held afterwards.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
         r_index <= '0;
         r_wdata <= '0;
         r_adr   <= BASE_ADDR;
         r_error <= 1'b0;
      end else begin
         if (w_start_seen) begin
            r_error <= w_illegal;
         end
         if (w_load_go) begin
            r_count <= i_word_count;
            r_index <= '0;
         end else if ((r_state == ST_WRITE) && !w_last) begin
            r_index <= r_index + CW'(1);
         end
         if (w_word_full) begin
            r_wdata <= w_word_next;
            r_adr   <= BASE_ADDR + (32'(r_index) * 32'(ADDR_STEP));
         end
      end
   end

   assign o_Ext_WriteData = r_wdata;
   assign o_Ext_DataAdr   = r_adr;
   assign o_error         = r_error;

endmodule
